// File: rtl/decode_pipe_if.sv
// Fetch, write-back and ID/EX bundle shared by decode_pipe and its neighbouring stages.
interface decode_pipe_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int RAW = $clog2(NREG);

    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;
    logic            flush;
    logic            wb_we;
    logic [RAW-1:0]  wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_ready;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [RAW-1:0]  ex_rs1;
    logic [RAW-1:0]  ex_rs2;
    logic [RAW-1:0]  ex_rd;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_memtoreg;
    logic            ex_alusrc;
    logic            ex_branch;
    logic            ex_jump;
    logic [1:0]      ex_aluop;

    modport master (
        output if_valid, if_instr, if_pc, flush, wb_we, wb_rd, wb_data, ex_ready,
        input  id_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
               ex_branch, ex_jump, ex_aluop
    );

    modport slave (
        input  if_valid, if_instr, if_pc, flush, wb_we, wb_rd, wb_data, ex_ready,
        output id_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5,
               ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
               ex_branch, ex_jump, ex_aluop
    );
endinterface

// File: rtl/decode_pipe.sv
// RV32I decode stage: register file with write-back bypass, control/immediate decode,
// load-use stall and a single ID/EX register with valid/ready back-pressure and flush.
module decode_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic         clock,
    input  logic         reset,
    decode_pipe_if.slave bus
);
    localparam int RAW = $clog2(NREG);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [RAW-1:0]  rd;
        logic [2:0]      funct3;
        logic            funct7b5;
        ctrl_t           ctrl;
    } idex_t;

    logic [XLEN-1:0] rf_q [NREG];
    idex_t           idex_q;
    idex_t           idex_d;

    logic [6:0]      opcode_s;
    logic [RAW-1:0]  rs1_s;
    logic [RAW-1:0]  rs2_s;
    logic [RAW-1:0]  rd_s;
    ctrl_t           ctrl_s;
    logic [31:0]     imm32_s;
    logic            rs1_used_s;
    logic            rs2_used_s;
    logic            load_use_s;
    logic            advance_s;
    logic [XLEN-1:0] rs1_data_s;
    logic [XLEN-1:0] rs2_data_s;

    function automatic logic [XLEN-1:0] rf_read(
        input logic [RAW-1:0]  idx,
        input logic [XLEN-1:0] stored,
        input logic            we,
        input logic [RAW-1:0]  wrd,
        input logic [XLEN-1:0] wdata
    );
        logic [XLEN-1:0] val;
        if (idx == '0) begin
            val = '0;
        end else if (we && (wrd == idx)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    assign opcode_s   = bus.if_instr[6:0];
    assign rs1_s      = bus.if_instr[15 +: RAW];
    assign rs2_s      = bus.if_instr[20 +: RAW];
    assign rd_s       = bus.if_instr[7 +: RAW];
    assign rs1_data_s = rf_read(rs1_s, rf_q[rs1_s], bus.wb_we, bus.wb_rd, bus.wb_data);
    assign rs2_data_s = rf_read(rs2_s, rf_q[rs2_s], bus.wb_we, bus.wb_rd, bus.wb_data);

    // Opcode decode: control bits, immediate format and which source registers are live
    always_comb begin
        ctrl_s     = '0;
        imm32_s    = 32'd0;
        rs1_used_s = 1'b1;
        rs2_used_s = 1'b0;
        case (opcode_s)
            OP_R: begin
                ctrl_s.regwrite = 1'b1;
                ctrl_s.aluop    = 2'b10;
                rs2_used_s      = 1'b1;
            end
            OP_I: begin
                ctrl_s.regwrite = 1'b1;
                ctrl_s.alusrc   = 1'b1;
                ctrl_s.aluop    = 2'b11;
                imm32_s         = {{20{bus.if_instr[31]}}, bus.if_instr[31:20]};
            end
            OP_LOAD: begin
                ctrl_s.regwrite = 1'b1;
                ctrl_s.memread  = 1'b1;
                ctrl_s.memtoreg = 1'b1;
                ctrl_s.alusrc   = 1'b1;
                imm32_s         = {{20{bus.if_instr[31]}}, bus.if_instr[31:20]};
            end
            OP_STORE: begin
                ctrl_s.memwrite = 1'b1;
                ctrl_s.alusrc   = 1'b1;
                rs2_used_s      = 1'b1;
                imm32_s         = {{20{bus.if_instr[31]}}, bus.if_instr[31:25], bus.if_instr[11:7]};
            end
            OP_BRANCH: begin
                ctrl_s.branch = 1'b1;
                ctrl_s.aluop  = 2'b01;
                rs2_used_s    = 1'b1;
                imm32_s       = {{19{bus.if_instr[31]}}, bus.if_instr[31], bus.if_instr[7],
                                 bus.if_instr[30:25], bus.if_instr[11:8], 1'b0};
            end
            OP_JAL: begin
                ctrl_s.regwrite = 1'b1;
                ctrl_s.jump     = 1'b1;
                rs1_used_s      = 1'b0;
                imm32_s         = {{11{bus.if_instr[31]}}, bus.if_instr[31], bus.if_instr[19:12],
                                   bus.if_instr[20], bus.if_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                ctrl_s.regwrite = 1'b1;
                ctrl_s.jump     = 1'b1;
                ctrl_s.alusrc   = 1'b1;
                imm32_s         = {{20{bus.if_instr[31]}}, bus.if_instr[31:20]};
            end
            OP_LUI, OP_AUIPC: begin
                ctrl_s.regwrite = 1'b1;
                ctrl_s.alusrc   = 1'b1;
                rs1_used_s      = 1'b0;
                imm32_s         = {bus.if_instr[31:12], 12'd0};
            end
            default: begin
                ctrl_s = '0;
            end
        endcase
        ctrl_s.regwrite = ctrl_s.regwrite & (rd_s != '0);
    end

    assign load_use_s = bus.if_valid & idex_q.valid & idex_q.ctrl.memread & (idex_q.rd != '0) &
                        ((rs1_used_s & (idex_q.rd == rs1_s)) | (rs2_used_s & (idex_q.rd == rs2_s)));
    assign advance_s  = bus.ex_ready | ~idex_q.valid;
    assign bus.id_ready = bus.flush | (advance_s & ~load_use_s);

    // ID/EX next state: flush beats everything, then advance (load or bubble), else hold
    always_comb begin
        idex_d = idex_q;
        if (bus.flush) begin
            idex_d = '0;
        end else if (advance_s) begin
            if (bus.if_valid && !load_use_s) begin
                idex_d.valid    = 1'b1;
                idex_d.pc       = bus.if_pc;
                idex_d.rs1_data = rs1_data_s;
                idex_d.rs2_data = rs2_data_s;
                idex_d.imm      = XLEN'($signed(imm32_s));
                idex_d.rs1      = rs1_s;
                idex_d.rs2      = rs2_s;
                idex_d.rd       = rd_s;
                idex_d.funct3   = bus.if_instr[14:12];
                idex_d.funct7b5 = bus.if_instr[30];
                idex_d.ctrl     = ctrl_s;
            end else begin
                idex_d = '0;
            end
        end else begin
            idex_d = idex_q;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    // Architectural register file; x0 is never written
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (bus.wb_we && (bus.wb_rd != '0)) begin
            rf_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign bus.ex_valid    = idex_q.valid;
    assign bus.ex_pc       = idex_q.pc;
    assign bus.ex_rs1_data = idex_q.rs1_data;
    assign bus.ex_rs2_data = idex_q.rs2_data;
    assign bus.ex_imm      = idex_q.imm;
    assign bus.ex_rs1      = idex_q.rs1;
    assign bus.ex_rs2      = idex_q.rs2;
    assign bus.ex_rd       = idex_q.rd;
    assign bus.ex_funct3   = idex_q.funct3;
    assign bus.ex_funct7b5 = idex_q.funct7b5;
    assign bus.ex_regwrite = idex_q.ctrl.regwrite;
    assign bus.ex_memread  = idex_q.ctrl.memread;
    assign bus.ex_memwrite = idex_q.ctrl.memwrite;
    assign bus.ex_memtoreg = idex_q.ctrl.memtoreg;
    assign bus.ex_alusrc   = idex_q.ctrl.alusrc;
    assign bus.ex_branch   = idex_q.ctrl.branch;
    assign bus.ex_jump     = idex_q.ctrl.jump;
    assign bus.ex_aluop    = idex_q.ctrl.aluop;
endmodule
